// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller: lamp encodings,
// state codes and a small helper for sizing the dwell counter.
package tlc_pkg;

  // Lamp encodings driven on the hwy/cntry outputs.
  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  // State codes; the numeric value is what appears on the phase output.
  typedef enum logic [2:0] {
    ST_HG  = 3'd0,
    ST_HY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_CG  = 3'd3,
    ST_CY  = 3'd4,
    ST_AR2 = 3'd5
  } state_e;

  // Largest of the five timing parameters, used to size the dwell counter.
  function automatic int max5(input int a, input int b, input int c,
                              input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Dwell counter: cleared on request, otherwise counts up once per cycle
// and sticks at all-ones so a long wait never wraps back to a small value.
module tlc_dwell_timer
  import tlc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register, forced to zero while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tlc_param.sv
// Highway / country-road traffic-light controller. Highway rests on green;
// a waiting country car requests a full yellow / all-red / green cycle.
// Lamps and phase are a pure decode of the state register.
module tlc_param
  import tlc_pkg::*;
#(
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int MIN_HG_CYC = 4,
  parameter int MIN_CG_CYC = 2,
  parameter int MAX_CG_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] phase,
  output logic       timeout
);

  localparam int MAXP = max5(YELLOW_CYC, ALLRED_CYC, MIN_HG_CYC,
                             MIN_CG_CYC, MAX_CG_CYC);
  localparam int CW   = $clog2(MAXP) + 1;

  // Terminal counts expressed at counter width.
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_CYC - 1);
  localparam logic [CW-1:0] HG_MIN   = CW'(MIN_HG_CYC - 1);
  localparam logic [CW-1:0] CG_MIN   = CW'(MIN_CG_CYC - 1);
  localparam logic [CW-1:0] CG_MAX   = CW'(MAX_CG_CYC - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt;
  logic          clr;

  // State register; reset parks the controller on highway green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HG;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic from the dwell count and the sensor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HG:  if (cnt >= HG_MIN && x)                     state_d = ST_HY;
      ST_HY:  if (cnt == YEL_LAST)                        state_d = ST_AR1;
      ST_AR1: if (cnt == AR_LAST)                         state_d = ST_CG;
      ST_CG:  if ((cnt >= CG_MIN && !x) || cnt == CG_MAX) state_d = ST_CY;
      ST_CY:  if (cnt == YEL_LAST)                        state_d = ST_AR2;
      ST_AR2: if (cnt == AR_LAST)                         state_d = ST_HG;
      // Unused encodings recover to highway green; the state change
      // also clears the counter.
      default:                                            state_d = ST_HG;
    endcase
  end

  // Lamp decode from the state register only; unknown states show all red.
  always_comb begin
    hwy   = LAMP_RED;
    cntry = LAMP_RED;
    case (state_q)
      ST_HG:   hwy   = LAMP_GREEN;
      ST_HY:   hwy   = LAMP_YELLOW;
      ST_CG:   cntry = LAMP_GREEN;
      ST_CY:   cntry = LAMP_YELLOW;
      default: begin
        hwy   = LAMP_RED;
        cntry = LAMP_RED;
      end
    endcase
  end

  assign phase   = state_q;
  // Flags the cycle whose edge will cut country green short at its maximum.
  assign timeout = (state_q == ST_CG) && (cnt == CG_MAX) && x;
  // Every state change restarts the dwell count.
  assign clr     = (state_d != state_q);

  tlc_dwell_timer #(
    .W (CW)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .cnt_o (cnt)
  );

endmodule

// File: tb/tb_tlc_param.sv
// Self-checking bench for tlc_param with default timing parameters.
module tb_tlc_param;
  import tlc_pkg::*;

  localparam int YEL = 3;
  localparam int AR  = 2;
  localparam int MHG = 4;
  localparam int MCG = 2;
  localparam int XCG = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] phase;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: current phase and cycles already spent in it.
  int m_ph = 0;
  int m_t  = 0;

  tlc_param #(
    .YELLOW_CYC (YEL),
    .ALLRED_CYC (AR),
    .MIN_HG_CYC (MHG),
    .MIN_CG_CYC (MCG),
    .MAX_CG_CYC (XCG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .hwy     (hwy),
    .cntry   (cntry),
    .phase   (phase),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       x;
    logic [2:0] ph;
    logic [1:0] hw;
    logic [1:0] cn;
    logic       to;
  } vec_t;

  function automatic logic [1:0] hwy_of(input int ph);
    if (ph == 0) return LAMP_GREEN;
    if (ph == 1) return LAMP_YELLOW;
    return LAMP_RED;
  endfunction

  function automatic logic [1:0] cntry_of(input int ph);
    if (ph == 3) return LAMP_GREEN;
    if (ph == 4) return LAMP_YELLOW;
    return LAMP_RED;
  endfunction

  task automatic cmp(input string tag, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] eph,
                           input logic [1:0] eh, input logic [1:0] ec,
                           input logic eto);
    cmp({tag, ".phase"}, int'(phase), int'(eph));
    cmp({tag, ".hwy"}, int'(hwy), int'(eh));
    cmp({tag, ".cntry"}, int'(cntry), int'(ec));
    cmp({tag, ".timeout"}, int'(timeout), int'(eto));
    cmp({tag, ".excl"}, int'(hwy != LAMP_RED && cntry != LAMP_RED), 0);
    $display("%s: x=%0b phase=%0d hwy=%02b cntry=%02b timeout=%0b",
             tag, x, phase, hwy, cntry, timeout);
  endtask

  // Assert reset across an edge and release it between edges.
  task automatic do_reset();
    rst = 1'b1;
    x   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_ph = 0;
    m_t  = 0;
  endtask

  // Hold x for n cycles, expecting phase ph throughout; timeout expected
  // only in the last cycle when to_last is set.
  task automatic hold(input string tag, input logic xv, input int ph,
                      input int n, input bit to_last);
    for (int i = 0; i < n; i++) begin
      x = xv;
      #1;
      check_out(tag, 3'(ph), hwy_of(ph), cntry_of(ph),
                to_last && (i == n - 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Advance the model one edge using the timing rules directly.
  task automatic model_edge(input bit xv);
    bit go;
    case (m_ph)
      0:       go = (m_t + 1 >= MHG) && xv;
      3:       go = ((m_t + 1 >= MCG) && !xv) || (m_t + 1 == XCG);
      1, 4:    go = (m_t + 1 == YEL);
      default: go = (m_t + 1 == AR);
    endcase
    if (go) begin
      m_ph = (m_ph + 1) % 6;
      m_t  = 0;
    end else if (m_t < 1000) begin
      m_t = m_t + 1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic xv;
    int   thresh;

    // REQ-022 style sequence: x=1 until country green, then x=0.
    tbl = '{
      '{1'b1, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0},
      '{1'b1, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0},
      '{1'b1, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0},
      '{1'b1, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0},
      '{1'b1, 3'd1, LAMP_YELLOW, LAMP_RED,    1'b0},
      '{1'b1, 3'd1, LAMP_YELLOW, LAMP_RED,    1'b0},
      '{1'b1, 3'd1, LAMP_YELLOW, LAMP_RED,    1'b0},
      '{1'b1, 3'd2, LAMP_RED,    LAMP_RED,    1'b0},
      '{1'b1, 3'd2, LAMP_RED,    LAMP_RED,    1'b0},
      '{1'b0, 3'd3, LAMP_RED,    LAMP_GREEN,  1'b0},
      '{1'b0, 3'd3, LAMP_RED,    LAMP_GREEN,  1'b0},
      '{1'b0, 3'd4, LAMP_RED,    LAMP_YELLOW, 1'b0},
      '{1'b0, 3'd4, LAMP_RED,    LAMP_YELLOW, 1'b0},
      '{1'b0, 3'd4, LAMP_RED,    LAMP_YELLOW, 1'b0},
      '{1'b0, 3'd5, LAMP_RED,    LAMP_RED,    1'b0},
      '{1'b0, 3'd5, LAMP_RED,    LAMP_RED,    1'b0},
      '{1'b0, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0},
      '{1'b0, 3'd0, LAMP_GREEN,  LAMP_RED,    1'b0}
    };

    // Reset state, checked while rst is still high.
    #2;
    check_out("reset", 3'd0, LAMP_GREEN, LAMP_RED, 1'b0);

    // Idle highway: x=0 for 20 cycles stays on highway green.
    do_reset();
    hold("idle", 1'b0, 0, 20, 1'b0);

    // Table-driven normal cycle.
    do_reset();
    foreach (tbl[i]) begin
      x = tbl[i].x;
      #1;
      check_out($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].hw, tbl[i].cn,
                tbl[i].to);
      @(posedge clk);
      #1;
    end

    // Country green capped at its maximum with timeout in the last cycle.
    do_reset();
    hold("tmo", 1'b1, 0, 4, 1'b0);
    hold("tmo", 1'b1, 1, 3, 1'b0);
    hold("tmo", 1'b1, 2, 2, 1'b0);
    hold("tmo", 1'b1, 3, 6, 1'b1);
    hold("tmo", 1'b1, 4, 3, 1'b0);
    hold("tmo", 1'b1, 5, 2, 1'b0);
    hold("tmo", 1'b1, 0, 4, 1'b0);
    hold("tmo", 1'b1, 1, 1, 1'b0);

    // Sensor pulses during yellow and all-red leave those dwells fixed.
    do_reset();
    hold("pulse", 1'b1, 0, 4, 1'b0);
    hold("pulse", 1'b0, 1, 1, 1'b0);
    hold("pulse", 1'b1, 1, 1, 1'b0);
    hold("pulse", 1'b0, 1, 1, 1'b0);
    hold("pulse", 1'b1, 2, 1, 1'b0);
    hold("pulse", 1'b0, 2, 1, 1'b0);
    hold("pulse", 1'b1, 3, 1, 1'b0);

    // Reset between edges in the second yellow cycle.
    do_reset();
    hold("midrst", 1'b1, 0, 4, 1'b0);
    hold("midrst", 1'b1, 1, 1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("midrst.async", 3'd0, LAMP_GREEN, LAMP_RED, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    hold("midrst.after", 1'b1, 0, 4, 1'b0);
    hold("midrst.after", 1'b1, 1, 1, 1'b0);

    // Randomised run against the reference model, with occasional resets.
    do_reset();
    thresh = 5;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) thresh = $urandom_range(0, 10);
      if ($urandom_range(0, 80) == 0) begin
        #2 rst = 1'b1;
        m_ph = 0;
        m_t  = 0;
        #1;
        check_out($sformatf("rnd%0d.rst", i), 3'd0, LAMP_GREEN, LAMP_RED,
                  1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
      end else begin
        xv = ($urandom_range(0, 9) < thresh);
        x  = xv;
        #1;
        check_out($sformatf("rnd%0d", i), 3'(m_ph), hwy_of(m_ph),
                  cntry_of(m_ph), (m_ph == 3) && (m_t == XCG - 1) && xv);
        @(posedge clk);
        model_edge(xv);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tlc_param.md
TLC_PARAM -- requirements
Module: tlc_param

Interface
REQ-001 SHALL have parameter YELLOW_CYC, default 3: yellow dwell for either road, in clock cycles (>=1).
REQ-002 SHALL have parameter ALLRED_CYC, default 2: all-red clearance dwell after each yellow, in cycles (>=1).
REQ-003 SHALL have parameter MIN_HG_CYC, default 4: minimum highway green dwell, in cycles (>=1).
REQ-004 SHALL have parameter MIN_CG_CYC, default 2: minimum country green dwell, in cycles (>=1).
REQ-005 SHALL have parameter MAX_CG_CYC, default 6: maximum country green dwell, in cycles (>=MIN_CG_CYC).
REQ-006 SHALL have ports, in order:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  1  country-road vehicle sensor, 1 = car waiting or present.
- hwy  output  2  highway lamp: 00 RED, 01 YELLOW, 10 GREEN.
- cntry  output  2  country lamp, same encoding.
- phase  output  3  current state code.
- timeout  output  1  one-cycle pulse when country green is ended by MAX_CG_CYC.

Function
REQ-007 SHALL implement six states, with phase codes and lamps:
- HG=0: hwy GREEN, cntry RED.
- HY=1: hwy YELLOW, cntry RED.
- AR1=2: both RED.
- CG=3: hwy RED, cntry GREEN.
- CY=4: hwy RED, cntry YELLOW.
- AR2=5: both RED.
REQ-008 SHALL decode hwy, cntry and phase combinationally from the state register only (Moore); x never affects the lamps directly.
REQ-009 SHALL keep one dwell counter cnt, width clog2(max parameter)+1:
- cleared to 0 on every state transition;
- otherwise incremented each cycle, saturating at all-ones.
REQ-010 SHALL take these transitions on the rising edge, using cnt and x as sampled at that edge:
- HG->HY when cnt>=MIN_HG_CYC-1 and x=1.
- HY->AR1 when cnt==YELLOW_CYC-1.
- AR1->CG when cnt==ALLRED_CYC-1.
- CG->CY when (cnt>=MIN_CG_CYC-1 and x=0) or cnt==MAX_CG_CYC-1.
- CY->AR2 when cnt==YELLOW_CYC-1.
- AR2->HG when cnt==ALLRED_CYC-1.
REQ-011 SHALL make fixed dwells exact: HY, CY = YELLOW_CYC cycles; AR1, AR2 = ALLRED_CYC cycles; x is ignored in these states.
REQ-012 SHALL hold HG indefinitely while x=0; x=1 arriving after the minimum dwell SHALL leave HG on the next edge.
REQ-013 SHALL assert timeout for exactly the cycle in which the state is CG and cnt==MAX_CG_CYC-1 and x=1; otherwise 0.
REQ-014 SHALL ensure no state ever shows GREEN or YELLOW on both roads at once.
REQ-015 SHALL route any unused state encoding to HG with cnt=0 on the next edge.

Reset
REQ-016 SHALL, while rst=1, asynchronously force state=HG and cnt=0, giving hwy=10, cntry=00, phase=0, timeout=0.
REQ-017 SHALL resume normal operation on the first rising clk after rst deasserts, with the HG minimum dwell counted from cnt=0.
REQ-018 SHALL allow rst mid-cycle in any state (including HY and CG) to abandon the sequence immediately; no yellow or all-red is completed.

Structure
REQ-019 SHALL place the lamp encodings (RED, YELLOW, GREEN) and the state codes in shared package tlc_pkg, used by tlc_param and the bench.
REQ-020 SHALL factor the dwell counter (clear, saturating increment, count output) into a sub-module tlc_dwell_timer, parameterised by width.

Verification (defaults: YELLOW 3, ALLRED 2, MIN_HG 4, MIN_CG 2, MAX_CG 6)
REQ-021 SHALL cover: reset, then x=0 for 20 cycles -> hwy=10, cntry=00, phase=0 throughout.
REQ-022 SHALL cover: x=1 from the first post-reset edge, then x=0 at CG entry ->
- HG 4 cycles, HY 3 (hwy=01), AR1 2 (both 00);
- CG 2, CY 3 (cntry=01), AR2 2;
- then HG.
REQ-023 SHALL cover: x held 1 ->
- CG lasts 6 cycles, with timeout=1 only in the 6th;
- then CY 3, AR2 2;
- HG lasts exactly 4 cycles before HY.
REQ-024 SHALL cover: x pulsed 0->1->0 inside HY and AR1 -> dwells unchanged at 3 and 2 cycles.
REQ-025 SHALL cover: rst asserted between edges in the 2nd HY cycle -> hwy=10, cntry=00 before the next edge; after release, HY again only after 4 HG cycles with x=1.
REQ-026 SHALL check on every cycle, in all scenarios, that hwy and cntry are never both non-RED (REQ-014).
